// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI arbiter:
//   arb_state_e      - arbiter FSM state encoding (also exported on state_o).
//   min_hold_cycles  - smallest ctrl_start hold time that covers one complete
//                      transfer of the attached controller.
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RESPOND = 3'd4
  } arb_state_e;

  // The controller spends 2 + CLOCK_DIVIDE cycles before the first bit and
  // 2*CLOCK_DIVIDE+2 cycles per bit; start must stay high for all of it.
  function automatic int min_hold_cycles(input int clock_divide, input int frame_width);
    return 2 + clock_divide + frame_width * (2 * clock_divide + 2);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. The search starts one past the
// previous owner and wraps from NUM_REQ-1 back to 0.
// Ports:
//   req_i          in  NUM_REQ  request vector
//   last_i         in  IDX_W    index of the previous owner
//   grant_o        out NUM_REQ  one-hot winner (zero when no request)
//   grant_idx_o    out IDX_W    winner index (last_i when no request)
//   grant_valid_o  out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o
);

  int idx;

  always_comb begin
    grant_o       = '0;
    grant_idx_o   = last_i;
    grant_valid_o = 1'b0;
    idx           = 0;
    // Offsets 1..NUM_REQ visit every requester once; the previous owner is
    // checked last so it only wins again when nobody else is asking.
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_i) + off) % NUM_REQ;
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = IDX_W'(idx);
        grant_o[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
// Shares one SPI controller between NUM_REQ requesters. A winner is picked
// round-robin while the controller is idle, its TX word is latched and
// presented to the controller, start is held for HOLD_CYCLES cycles, and the
// received word is returned to the owner with a one-cycle completion pulse.
//
// Handshake: requester k is accepted on the cycle where req_valid_i[k] and
// req_ready_o[k] are both high. req_ready_o is a single-cycle one-hot pulse
// and never depends on anything after that cycle; a requester that drops
// valid before seeing ready simply is not selected. rsp_valid_o is a
// single-cycle one-hot pulse with no back-pressure; rsp_data_o is valid with
// it and holds its value afterwards.
//
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   req_valid_i        per-requester request level
//   req_data_i         per-requester TX word, requester k at [k*FW +: FW]
//   req_ready_o        one-hot acceptance pulse
//   rsp_valid_o        one-hot completion pulse to the owner
//   rsp_data_o         received word
//   ctrl_start_o       controller start
//   ctrl_idle_i        controller idle flag
//   ctrl_data_o        TX word to the controller
//   ctrl_data_i        RX word from the controller
//   busy_o             high in every state except IDLE
//   grant_id_o         index of the current/last owner
//   state_o            FSM state (observation only)
// -----------------------------------------------------------------------------
module spi_arbiter
  import spi_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int FRAME_WIDTH = 32,
  parameter  int HOLD_CYCLES = 200,
  localparam int IDX_W       = $clog2(NUM_REQ),
  localparam int CNT_W       = $clog2(HOLD_CYCLES)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [FRAME_WIDTH-1:0]         rsp_data_o,
  output logic                           ctrl_start_o,
  input  logic                           ctrl_idle_i,
  output logic [FRAME_WIDTH-1:0]         ctrl_data_o,
  input  logic [FRAME_WIDTH-1:0]         ctrl_data_i,
  output logic                           busy_o,
  output logic [IDX_W-1:0]               grant_id_o,
  output arb_state_e                     state_o
);

  if (NUM_REQ < 2) begin : g_num_req_low
    $error("spi_arbiter: NUM_REQ must be at least 2");
  end
  if (NUM_REQ > 16) begin : g_num_req_high
    $error("spi_arbiter: NUM_REQ must be at most 16");
  end
  if (HOLD_CYCLES < 2) begin : g_hold_low
    $error("spi_arbiter: HOLD_CYCLES must be at least 2");
  end

  arb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_WIDTH-1:0] tx_q, tx_d;
  logic [FRAME_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDX_W-1:0]       grant_q, grant_d;

  logic [NUM_REQ-1:0]     rr_grant;
  logic [IDX_W-1:0]       rr_idx;
  logic                   rr_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i         (req_valid_i),
    .last_i        (grant_q),
    .grant_o       (rr_grant),
    .grant_idx_o   (rr_idx),
    .grant_valid_o (rr_valid)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_q       <= '0;
      rsp_data_q <= '0;
      // Last owner = NUM_REQ-1 so the first search starts at requester 0.
      grant_q    <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rsp_data_q <= rsp_data_d;
      grant_q    <= grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_d         = tx_q;
    rsp_data_d   = rsp_data_q;
    grant_d      = grant_q;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    ctrl_start_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_idle_i && rr_valid) begin
          req_ready_o = rr_grant;
          tx_d        = req_data_i[rr_idx*FRAME_WIDTH +: FRAME_WIDTH];
          grant_d     = rr_idx;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // TX word settles on ctrl_data_o for one cycle before start rises.
        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        state_d = ST_START;
      end
      ST_START: begin
        ctrl_start_o = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (ctrl_idle_i) begin
          rsp_data_d = ctrl_data_i;
          state_d    = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        rsp_valid_o[grant_q] = 1'b1;
        state_d              = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ctrl_data_o = tx_q;
  assign rsp_data_o  = rsp_data_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_arbiter
// Bench for spi_arbiter with a bit-serial SPI controller model
// (CLOCK_DIVIDE=2, 32-bit frame, MISO looped to MOSI) attached.
// -----------------------------------------------------------------------------
module tb_spi_arbiter;
  import spi_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int FW      = 32;
  localparam int HOLD    = 200;
  localparam int CD      = 2;
  localparam int IDX_W   = 2;
  localparam int LEAD    = 2 + CD;
  localparam int BIT_CYC = 2 * CD + 2;
  localparam int TMO     = 1000;

  if (HOLD < min_hold_cycles(CD, FW)) begin : g_hold_chk
    $error("HOLD shorter than one controller transfer");
  end

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_i;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ*FW-1:0] req_data_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ-1:0]    rsp_valid_o;
  logic [FW-1:0]         rsp_data_o;
  logic                  ctrl_start_o;
  logic                  ctrl_idle_i;
  logic [FW-1:0]         ctrl_data_o;
  logic [FW-1:0]         ctrl_data_i;
  logic                  busy_o;
  logic [IDX_W-1:0]      grant_id_o;
  arb_state_e            state_o;

  spi_arbiter #(.NUM_REQ(NUM_REQ), .FRAME_WIDTH(FW), .HOLD_CYCLES(HOLD)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .ctrl_start_o (ctrl_start_o),
    .ctrl_idle_i  (ctrl_idle_i),
    .ctrl_data_o  (ctrl_data_o),
    .ctrl_data_i  (ctrl_data_i),
    .busy_o       (busy_o),
    .grant_id_o   (grant_id_o),
    .state_o      (state_o)
  );

  // ---------------- SPI controller model ----------------
  typedef enum logic [1:0] {C_IDLE, C_BUSY, C_DONE} ctl_e;
  ctl_e          c_st;
  int            c_cnt;
  int            c_bits;
  logic [FW-1:0] c_sh;
  logic [FW-1:0] c_rx;
  logic          force_busy;
  logic          mosi;
  logic          miso;

  assign mosi        = c_sh[FW-1];
  assign miso        = mosi;
  assign ctrl_idle_i = (c_st == C_IDLE) && !force_busy;
  assign ctrl_data_i = c_rx;

  always @(posedge clk) begin
    if (reset_i) begin
      c_st   <= C_IDLE;
      c_cnt  <= 0;
      c_bits <= 0;
      c_sh   <= '0;
      c_rx   <= '0;
    end else begin
      case (c_st)
        C_IDLE: if (ctrl_start_o) begin
          c_sh   <= ctrl_data_o;
          c_cnt  <= 0;
          c_bits <= 0;
          c_st   <= C_BUSY;
        end
        C_BUSY: if (!ctrl_start_o) begin
          c_st <= C_IDLE;
        end else begin
          c_cnt <= c_cnt + 1;
          if (c_cnt >= LEAD - 1 && ((c_cnt - (LEAD - 1)) % BIT_CYC) == BIT_CYC - 1) begin
            c_sh   <= {c_sh[FW-2:0], miso};
            c_bits <= c_bits + 1;
            if (c_bits == FW - 1) begin
              c_rx <= {c_sh[FW-2:0], miso};
              c_st <= C_DONE;
            end
          end
        end
        default: if (!ctrl_start_o) c_st <= C_IDLE;
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;
  logic [IDX_W+FW-1:0] exp_q[$];
  logic [IDX_W+FW-1:0] mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int k);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int start_run    = 0;
  int hold_len     = 0;
  int ready_cyc    = 0;
  int last_rsp_cyc = -10;

  always @(negedge clk) begin
    if (reset_i) begin
      start_run = 0;
    end else begin
      if (ctrl_start_o === 1'b1) begin
        start_run++;
      end else if (start_run != 0) begin
        hold_len  = start_run;
        start_run = 0;
      end
      if (req_ready_o != '0) ready_cyc = cyc;
      if (rsp_valid_o != '0) begin
        last_rsp_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_rsp observed=%0h expected=none", rsp_valid_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_valid", 64'(rsp_valid_o), 64'(onehot(int'(mon_e[FW +: IDX_W]))));
          check("rsp_data", 64'(rsp_data_o), 64'(mon_e[FW-1:0]));
          check("rsp_latency_min", 64'((cyc - ready_cyc) >= HOLD + 3), 64'(1));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int k, input logic [FW-1:0] d);
    req_data_i[k*FW +: FW] = d;
    req_valid_i[k]         = 1'b1;
  endtask

  // Waits for the next ready pulse, checks it targets k, then withdraws k.
  task automatic accept(input int k, input bit b2b, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready_o == '0 && n < TMO);
    check("ready_onehot", 64'(req_ready_o), 64'(onehot(k)));
    if (b2b) check("ready_back_to_back", 64'(cyc - last_rsp_cyc), 64'(1));
    @(posedge clk);
    #1;
    req_valid_i[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    reset_i     = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    force_busy  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", 64'(req_ready_o), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check("rst_rsp_data", 64'(rsp_data_o), 64'(0));
    check("rst_start", 64'(ctrl_start_o), 64'(0));
    check("rst_ctrl_data", 64'(ctrl_data_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_grant", 64'(grant_id_o), 64'(NUM_REQ - 1));
    check("rst_state", 64'(state_o), 64'(ST_IDLE));

    // Single request on requester 2
    @(posedge clk);
    #1;
    set_req(2, 32'hA5A5_1234);
    exp_q.push_back({2'd2, 32'hA5A5_1234});
    accept(2, 1'b0, n);
    check("grant_single", 64'(grant_id_o), 64'(2));
    check("busy_single", 64'(busy_o), 64'(1));
    drain();
    check("hold_single", 64'(hold_len), 64'(HOLD));

    // Restore priority to requester 0
    @(posedge clk);
    #1 reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    check("grant_after_reset", 64'(grant_id_o), 64'(NUM_REQ - 1));

    // All four at once: served 0,1,2,3 back to back
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      set_req(k, FW'(k));
      exp_q.push_back({IDX_W'(k), FW'(k)});
    end
    for (int k = 0; k < NUM_REQ; k++) accept(k, k != 0, n);
    drain();
    check("hold_all", 64'(hold_len), 64'(HOLD));

    // Wrap: last owner 3, requests on 1 and 3
    check("grant_before_wrap", 64'(grant_id_o), 64'(3));
    @(posedge clk);
    #1;
    set_req(1, 32'hDEAD_0001);
    set_req(3, 32'hBEEF_0003);
    exp_q.push_back({2'd1, 32'hDEAD_0001});
    exp_q.push_back({2'd3, 32'hBEEF_0003});
    accept(1, 1'b0, n);
    accept(3, 1'b1, n);
    drain();

    // Controller reports busy: request must wait
    @(posedge clk);
    #1;
    force_busy = 1'b1;
    set_req(0, 32'h1DE1_0000);
    exp_q.push_back({2'd0, 32'h1DE1_0000});
    repeat (10) begin
      @(negedge clk);
      check("ready_while_ctrl_busy", 64'(req_ready_o), 64'(0));
    end
    @(posedge clk);
    #1 force_busy = 1'b0;
    accept(0, 1'b0, n);
    check("ready_on_idle_return", 64'(n), 64'(1));
    drain();

    // Reset 50 cycles into START aborts the transfer
    @(posedge clk);
    #1;
    set_req(2, 32'hBAD0_BAD0);
    accept(2, 1'b0, n);
    n = 0;
    while (ctrl_start_o !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 64'(ctrl_start_o), 64'(1));
    repeat (49) @(negedge clk);
    check("start_before_abort", 64'(ctrl_start_o), 64'(1));
    @(posedge clk);
    #1 reset_i = 1'b1;
    @(posedge clk);
    #1;
    check("abort_start_low", 64'(ctrl_start_o), 64'(0));
    check("abort_state", 64'(state_o), 64'(ST_IDLE));
    check("abort_grant", 64'(grant_id_o), 64'(NUM_REQ - 1));
    reset_i = 1'b0;
    repeat (300) @(negedge clk);
    check("abort_no_rsp_data", 64'(rsp_data_o), 64'(0));

    // After the abort requester 0 goes first, then 2
    @(posedge clk);
    #1;
    set_req(0, 32'h0F0F_F0F0);
    set_req(2, 32'h1357_2468);
    exp_q.push_back({2'd0, 32'h0F0F_F0F0});
    exp_q.push_back({2'd2, 32'h1357_2468});
    accept(0, 1'b0, n);
    accept(2, 1'b1, n);
    drain();
    check("hold_after_abort", 64'(hold_len), 64'(HOLD));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one SPI controller (2..16).
REQ-002 Parameter FRAME_WIDTH, default 32, SPI frame width in bits; equals the controller's frame width.
REQ-003 Parameter HOLD_CYCLES, default 200, cycles ctrl_start_o is held high per transfer; SHALL be >= 2 + CLOCK_DIVIDE + FRAME_WIDTH*(2*CLOCK_DIVIDE+2) of the attached controller.
REQ-004 clk_i  input  1  FPGA clock; single clock domain.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 req_valid_i  input  NUM_REQ  per-requester transfer request, level.
REQ-007 req_data_i  input  NUM_REQ*FRAME_WIDTH  per-requester TX word; requester k occupies bits [k*FRAME_WIDTH +: FRAME_WIDTH].
REQ-008 req_ready_o  output  NUM_REQ  one-hot acceptance pulse.
REQ-009 rsp_valid_o  output  NUM_REQ  one-hot completion pulse to the owning requester.
REQ-010 rsp_data_o  output  FRAME_WIDTH  received word, valid while rsp_valid_o is nonzero, held otherwise.
REQ-011 ctrl_start_o  output  1  drives controller start.
REQ-012 ctrl_idle_i  input  1  controller idle flag.
REQ-013 ctrl_data_o  output  FRAME_WIDTH  TX word to controller.
REQ-014 ctrl_data_i  input  FRAME_WIDTH  RX word from controller.
REQ-015 busy_o  output  1  high in every state except IDLE.
REQ-016 grant_id_o  output  $clog2(NUM_REQ)  index of the current/last owner.

Function
REQ-017 FSM states: IDLE, LOAD, START, RELEASE, RESPOND.
REQ-018 IDLE: when ctrl_idle_i=1 and any req_valid_i bit=1, select the winner round-robin, pulse req_ready_o[winner] for this cycle only, latch req_data_i of the winner into the TX register, latch the winner into grant_id_o, go to LOAD.
REQ-019 IDLE with ctrl_idle_i=0 SHALL not accept; no ready pulse.
REQ-020 Round-robin: search starts at grant_id_o+1 modulo NUM_REQ; index NUM_REQ-1 wraps to 0.
REQ-021 LOAD: ctrl_data_o presents the TX register, ctrl_start_o=0, one cycle, then START.
REQ-022 ctrl_data_o SHALL equal the TX register in all states, stable from LOAD through RELEASE.
REQ-023 START: ctrl_start_o=1; down-counter loaded with HOLD_CYCLES-1 on entry; exits to RELEASE the cycle after the counter reaches 0 (exactly HOLD_CYCLES cycles high).
REQ-024 RELEASE: ctrl_start_o=0; wait for ctrl_idle_i=1; on that cycle capture ctrl_data_i into rsp_data_o and go to RESPOND.
REQ-025 RESPOND: rsp_valid_o[grant_id_o]=1 for exactly one cycle, then IDLE.
REQ-026 Latency: acceptance pulse to rsp_valid_o pulse >= HOLD_CYCLES+3 cycles; back-to-back requests SHALL be accepted in the first IDLE cycle after RESPOND.
REQ-027 req_valid_i changes during a transfer SHALL not affect the transfer in flight; a requester dropping valid before its ready pulse loses its turn without side effects.
REQ-028 Simultaneous requests: exactly one ready bit per acceptance; losers are served in round-robin order.
REQ-029 Counter width $clog2(HOLD_CYCLES); no wrap-around is permitted.

Reset
REQ-030 reset_i SHALL force state IDLE, ctrl_start_o=0, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, TX register=0, counter=0, and grant_id_o=NUM_REQ-1, so that requester 0 has first priority.
REQ-031 Reset mid-transfer SHALL deassert ctrl_start_o on the next edge; the aborted transfer produces no rsp_valid_o.

Structure
REQ-032 Shared package spi_pkg SHALL hold the arbiter state enum and the function computing the minimum HOLD_CYCLES from CLOCK_DIVIDE and FRAME_WIDTH.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (request vector and last grant in, one-hot grant plus index out), purely combinational.
REQ-034 A parameter check SHALL raise an elaboration error when NUM_REQ < 2.

Verification
REQ-035 Bench attaches a real SPI controller (CLOCK_DIVIDE=2, FRAME_WIDTH=32) with MISO looped to MOSI.
REQ-036 Single request: req_valid_i[2]=1, data 0xA5A5_1234 -> req_ready_o[2] pulse, ctrl_start_o high 200 cycles, rsp_valid_o[2] pulse with rsp_data_o=0xA5A5_1234.
REQ-037 All four valid after reset, data 0x0..0x3 -> grants in order 0,1,2,3; each rsp_data_o matches its TX word.
REQ-038 Wrap: last grant 3, requests on 1 and 3 -> 1 granted before 3.
REQ-039 ctrl_idle_i forced 0 for 10 cycles with a pending request -> no ready pulse until it returns to 1.
REQ-040 reset_i pulsed 50 cycles into START -> ctrl_start_o low next cycle, no rsp_valid_o, next grant goes to requester 0.
